// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - Keccak state geometry, FSM states and the shared chi inverse table
package keccak_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int ROW_W     = 5;
    localparam int STATE_W   = 1600;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [31:0][ROW_W-1:0] lut_t;

    // Lane L occupies [STATE_W-1-64L -: 64]; this is its least significant bit index.
    function automatic int lane_lo(input int lane);
        return STATE_W - LANE_W * (lane + 1);
    endfunction

    function automatic logic [ROW_W-1:0] chi_row(input logic [ROW_W-1:0] a);
        logic [ROW_W-1:0] b;
        b = '0;
        for (int x = 0; x < ROW_W; x++) begin
            b[x] = a[x] ^ (~a[(x + 1) % ROW_W] & a[(x + 2) % ROW_W]);
        end
        return b;
    endfunction

    // Inverting the forward row map at elaboration keeps the table provably a bijection.
    function automatic lut_t build_chi_inv_lut();
        lut_t lut;
        lut = '0;
        for (int v = 0; v < 32; v++) begin
            lut[chi_row(ROW_W'(v))] = ROW_W'(v);
        end
        return lut;
    endfunction

    localparam lut_t CHI_INV_LUT = build_chi_inv_lut();

endpackage

// File: rtl/chi_inv_row.sv
// rtl/chi_inv_row.sv - 5-bit inverse chi row, pure table lookup
module chi_inv_row
    import keccak_pkg::*;
(
    input  logic [ROW_W-1:0] b_row,
    output logic [ROW_W-1:0] a_row
);

    assign a_row = CHI_INV_LUT[b_row];

endmodule

// File: rtl/keccak_chi_inv.sv
// rtl/keccak_chi_inv.sv - slice-serial inverse of Keccak chi with valid/ready handshakes
module keccak_chi_inv
    import keccak_pkg::*;
#(
    parameter int SLICES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data
);

    localparam int STEPS = LANE_W / SLICES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
    localparam int NROWS = SLICES * ROW_W;

    if (!(SLICES == 1 || SLICES == 2 || SLICES == 4 || SLICES == 8 ||
          SLICES == 16 || SLICES == 32 || SLICES == 64)) begin : g_bad_slices
        $error("keccak_chi_inv: SLICES must be a power of two from 1 to 64");
    end

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [STATE_W-1:0] state_buf;
    logic [5:0]         base;
    logic [SLICES-1:0]  chunk_cur [NUM_LANES];
    logic [SLICES-1:0]  chunk_new [NUM_LANES];
    logic [NROWS*ROW_W-1:0] rows_b, rows_a;

    assign base     = 6'(int'(cnt) * SLICES);
    assign out_data = state_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt == LAST) state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Gather the active z window of every lane, then regroup it into rows (slice s, plane y).
    always_comb begin
        rows_b = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            chunk_cur[l] = state_buf[lane_lo(l) + int'(base) +: SLICES];
            chunk_new[l] = '0;
        end
        for (int s = 0; s < SLICES; s++) begin
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < ROW_W; x++) begin
                    rows_b[(s * 5 + y) * ROW_W + x] = chunk_cur[5 * y + x][s];
                    chunk_new[5 * y + x][s]         = rows_a[(s * 5 + y) * ROW_W + x];
                end
            end
        end
    end

    for (genvar r = 0; r < NROWS; r++) begin : g_row
        chi_inv_row u_row (
            .b_row (rows_b[r * ROW_W +: ROW_W]),
            .a_row (rows_a[r * ROW_W +: ROW_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_buf <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_buf <= in_data;
                        cnt       <= '0;
                    end
                end
                ST_BUSY: begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        state_buf[lane_lo(l) + int'(base) +: SLICES] <= chunk_new[l];
                    end
                    cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_chi_inv.sv
// tb/tb_keccak_chi_inv.sv - self-checking bench for keccak_chi_inv at SLICES 1, 8 and 64
module tb_keccak_chi_inv;

    localparam int NI = 3;
    localparam int SLV [NI] = '{1, 8, 64};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid  [NI];
    logic          in_ready  [NI];
    logic          out_valid [NI];
    logic          out_ready [NI];
    logic [1599:0] in_data   [NI];
    logic [1599:0] out_data  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        keccak_chi_inv #(.SLICES(SLV[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1599:0] din;
        logic [1599:0] dout;
    } vec_t;

    task automatic check(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bit_idx(input int lane, input int z);
        return 1536 - 64 * lane + z;
    endfunction

    // Forward chi straight from the row equation, one (y,z) row at a time.
    function automatic logic [1599:0] chi_fwd(input logic [1599:0] a);
        logic [1599:0] b;
        b = '0;
        for (int y = 0; y < 5; y++)
            for (int z = 0; z < 64; z++)
                for (int x = 0; x < 5; x++)
                    b[bit_idx(5 * y + x, z)] = a[bit_idx(5 * y + x, z)] ^
                        (~a[bit_idx(5 * y + (x + 1) % 5, z)] & a[bit_idx(5 * y + (x + 2) % 5, z)]);
        return b;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] a;
        for (int w = 0; w < 50; w++) a[w * 32 +: 32] = $urandom();
        return a;
    endfunction

    task automatic run_txn(input int k, input logic [1599:0] b, output logic [1599:0] a,
                           output int lat, output bit ok, output longint t_acc);
        ok = 1'b0; lat = 0; a = '0; t_acc = 0;
        @(negedge clk);
        in_data[k] = b; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
        for (int t = 0; t < 200 && !in_ready[k]; t++) @(negedge clk);
        if (!in_ready[k]) begin
            in_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        #1 in_valid[k] = 1'b0;
        lat = 1;
        for (int t = 0; t < 200; t++) begin
            if (out_valid[k]) begin
                a = out_data[k];
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1 lat++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t          vt [3];
        logic [1599:0] a, b, got, held;
        int            lat, n;
        bit            ok;
        longint        t0, t1;

        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_in_ready_%0d", k), 1600'(in_ready[k]), 1600'(1));
            check($sformatf("reset_out_valid_%0d", k), 1600'(out_valid[k]), 1600'(0));
            check($sformatf("reset_out_data_%0d", k), out_data[k], '0);
        end
        @(negedge clk) rst = 1'b0;

        vt[0].din = '0;  vt[0].dout = '0;
        vt[1].din = '1;  vt[1].dout = '1;
        vt[2].din = '0;  vt[2].din[1599] = 1'b1; vt[2].din[1407] = 1'b1;
        vt[2].dout = '0; vt[2].dout[1599] = 1'b1;

        for (int k = 0; k < NI; k++) begin
            for (int v = 0; v < 3; v++) begin
                run_txn(k, vt[v].din, got, lat, ok, t0);
                check($sformatf("vec%0d_done_s%0d", v, SLV[k]), 1600'(ok), 1600'(1));
                check($sformatf("vec%0d_data_s%0d", v, SLV[k]), got, vt[v].dout);
                if (v == 0)
                    check($sformatf("latency_s%0d", SLV[k]), 1600'(lat), 1600'(64 / SLV[k] + 1));
            end
        end

        for (int k = 0; k < NI; k++) begin
            n = (k == 0) ? 600 : 1000;
            t1 = 0;
            for (int i = 0; i < n; i++) begin
                a = rand_state();
                run_txn(k, chi_fwd(a), got, lat, ok, t0);
                check($sformatf("rand%0d_done_s%0d", i, SLV[k]), 1600'(ok), 1600'(1));
                check($sformatf("rand%0d_data_s%0d", i, SLV[k]), got, a);
                if (i == 1)
                    check($sformatf("throughput_s%0d", SLV[k]), 1600'((t0 - t1) / 10),
                          1600'(64 / SLV[k] + 2));
                t1 = t0;
            end
        end

        // Output stall with an input pulse that must be ignored.
        a = rand_state();
        @(negedge clk);
        in_data[1] = chi_fwd(a); in_valid[1] = 1'b1; out_ready[1] = 1'b0;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        for (int t = 0; t < 50 && !out_valid[1]; t++) begin
            @(posedge clk);
            #1;
        end
        check("stall_reached_done", 1600'(out_valid[1]), 1600'(1));
        check("stall_data", out_data[1], a);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_data[1] = rand_state(); in_valid[1] = 1'b1;
            end
            @(posedge clk);
            #1 in_valid[1] = 1'b0;
            check($sformatf("stall_hold_data_%0d", c), out_data[1], a);
            check($sformatf("stall_in_ready_%0d", c), 1600'(in_ready[1]), 1600'(0));
            check($sformatf("stall_out_valid_%0d", c), 1600'(out_valid[1]), 1600'(1));
        end
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 1600'(out_valid[1]), 1600'(0));
        check("release_in_ready", 1600'(in_ready[1]), 1600'(1));
        repeat (12) @(posedge clk);
        #1;
        check("pulse_ignored_out_valid", 1600'(out_valid[1]), 1600'(0));
        check("pulse_ignored_in_ready", 1600'(in_ready[1]), 1600'(1));

        // Reset halfway through BUSY.
        a = rand_state();
        @(negedge clk);
        in_data[1] = chi_fwd(a); in_valid[1] = 1'b1; out_ready[1] = 1'b1;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        check("rst_busy_out_valid", 1600'(out_valid[1]), 1600'(0));
        check("rst_busy_in_ready", 1600'(in_ready[1]), 1600'(1));
        check("rst_busy_out_data", out_data[1], '0);
        @(negedge clk) rst = 1'b0;
        a = rand_state();
        run_txn(1, chi_fwd(a), got, lat, ok, t0);
        check("after_rst_done", 1600'(ok), 1600'(1));
        check("after_rst_data", got, a);

        // Reset while parked in DONE.
        a = rand_state();
        @(negedge clk);
        in_data[2] = chi_fwd(a); in_valid[2] = 1'b1; out_ready[2] = 1'b0;
        @(posedge clk);
        #1 in_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_before_rst", 1600'(out_valid[2]), 1600'(1));
        @(negedge clk) rst = 1'b1;
        #1;
        check("rst_done_out_valid", 1600'(out_valid[2]), 1600'(0));
        check("rst_done_in_ready", 1600'(in_ready[2]), 1600'(1));
        @(negedge clk) rst = 1'b0;
        a = rand_state();
        run_txn(2, chi_fwd(a), got, lat, ok, t0);
        check("after_rst2_done", 1600'(ok), 1600'(1));
        check("after_rst2_data", got, a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
